// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared definitions for the multi-cycle MIPS main control:
//            opcode constants, the state encoding, datapath select
//            encodings and the bundle of control outputs.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // Opcodes (instruction[31:26]) recognised by the controller
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // State codes are visible on the debug port, so they are pinned
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11,
      S_TRAP      = 4'd15
   } state_t;

   // ALU operand B select
   localparam logic [1:0] c_srcb_reg      = 2'b00;
   localparam logic [1:0] c_srcb_four     = 2'b01;
   localparam logic [1:0] c_srcb_imm      = 2'b10;
   localparam logic [1:0] c_srcb_imm_sll2 = 2'b11;

   // ALU operation
   localparam logic [1:0] c_aluop_add   = 2'b00;
   localparam logic [1:0] c_aluop_sub   = 2'b01;
   localparam logic [1:0] c_aluop_funct = 2'b10;

   // Next-PC source
   localparam logic [1:0] c_pcsrc_alu    = 2'b00;
   localparam logic [1:0] c_pcsrc_aluout = 2'b01;
   localparam logic [1:0] c_pcsrc_jump   = 2'b10;

   typedef struct packed {
      logic       PCWrite;
      logic       PCWriteCond;
      logic       IorD;
      logic       MemRead;
      logic       MemWrite;
      logic       IRWrite;
      logic       MemtoReg;
      logic       RegWrite;
      logic       RegDst;
      logic       ALUSrcA;
      logic [1:0] ALUSrcB;
      logic [1:0] ALUOp;
      logic [1:0] PCSource;
      logic       illegal_op;
   } ctrl_t;

   // True on the last cycle of an instruction; a store only finishes
   // once memory accepts it.
   function automatic logic is_final(state_t s, logic mem_ready);
      case (s)
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: return 1'b1;
         S_MEM_WRITE:                                   return mem_ready;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control_if
// Purpose  : Bundle between the main control FSM and the datapath.
// Ports    : master - controller view (opCode/zero/mem_ready in, controls,
//                     state, illegal_op, retired out)
//            slave  - datapath view (directions reversed)
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_control_if #(
   parameter int COUNT_W = 32
);
   logic [5:0]         opCode;
   logic               zero;
   logic               mem_ready;
   logic               PCWrite;
   logic               PCWriteCond;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               IRWrite;
   logic               MemtoReg;
   logic               RegWrite;
   logic               RegDst;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ALUOp;
   logic [1:0]         PCSource;
   logic [3:0]         state;
   logic               illegal_op;
   logic [COUNT_W-1:0] retired;

   modport master (
      input  opCode, zero, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             state, illegal_op, retired
   );

   modport slave (
      output opCode, zero, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             state, illegal_op, retired
   );
endinterface
`default_nettype wire

// File: rtl/mips_ctrl_outputs.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_outputs
// Purpose  : Combinational state-to-control decode (Moore outputs). The
//            only input dependence is the fetch handshake: PC and IR are
//            written only on the cycle memory delivers the instruction.
// Ports    : state     - current FSM state
//            mem_ready - memory access completes this cycle
//            ctrl      - all datapath controls plus illegal_op
// Revision : 1.0 - initial release
// ============================================================================
module mips_ctrl_outputs
   import mips_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.MemRead = 1'b1;
            ctrl.ALUSrcB = c_srcb_four;
            ctrl.IRWrite = mem_ready;
            ctrl.PCWrite = mem_ready;
         end
         S_DECODE: begin
            ctrl.ALUSrcB = c_srcb_imm_sll2;
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            ctrl.ALUSrcA = 1'b1;
            ctrl.ALUSrcB = c_srcb_imm;
         end
         S_MEM_READ: begin
            ctrl.MemRead = 1'b1;
            ctrl.IorD    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.RegWrite = 1'b1;
            ctrl.MemtoReg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.MemWrite = 1'b1;
            ctrl.IorD     = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.ALUSrcA = 1'b1;
            ctrl.ALUOp   = c_aluop_funct;
         end
         S_R_WB: begin
            ctrl.RegWrite = 1'b1;
            ctrl.RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.ALUSrcA     = 1'b1;
            ctrl.ALUOp       = c_aluop_sub;
            ctrl.PCWriteCond = 1'b1;
            ctrl.PCSource    = c_pcsrc_aluout;
         end
         S_JUMP: begin
            ctrl.PCWrite  = 1'b1;
            ctrl.PCSource = c_pcsrc_jump;
         end
         S_ADDI_WB: begin
            ctrl.RegWrite = 1'b1;
         end
         S_TRAP: begin
            ctrl.illegal_op = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Multi-cycle main control FSM for the MIPS core. Sequences
//            fetch/decode/execute/memory/write-back, stalls on mem_ready,
//            traps unsupported opcodes and counts retired instructions.
// Ports    : clk   - rising-edge clock
//            reset - synchronous, active-high
//            bus   - master side of mips_multicycle_control_if
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_control
   import mips_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   mips_multicycle_control_if.master   bus
);

   state_t             r_state;
   state_t             w_next;
   logic [COUNT_W-1:0] r_retired;
   ctrl_t              w_ctrl;
   ctrl_t              w_ctrl_out;
   logic               w_unused_zero;

   // The branch decision is made in the datapath (PCWriteCond & zero)
   assign w_unused_zero = bus.zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (is_final(r_state, bus.mem_ready))
            r_retired <= r_retired + COUNT_W'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:     if (bus.mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (bus.opCode)
               OP_RTYPE:     w_next = S_EXECUTE;
               OP_LW, OP_SW: w_next = S_MEM_ADDR;
               OP_BEQ:       w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               OP_ADDI:      w_next = S_ADDI_EX;
               default:      w_next = S_TRAP;
            endcase
         end
         S_MEM_ADDR:  w_next = (bus.opCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (bus.mem_ready) w_next = S_MEM_WB;
         S_MEM_WRITE: if (bus.mem_ready) w_next = S_FETCH;
         S_EXECUTE:   w_next = S_R_WB;
         S_ADDI_EX:   w_next = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                      w_next = S_FETCH;
         S_TRAP:      w_next = S_TRAP;
         default:     w_next = S_TRAP;  // unused codes are treated as a fault
      endcase
   end

   mips_ctrl_outputs u_outputs (
      .state     (r_state),
      .mem_ready (bus.mem_ready),
      .ctrl      (w_ctrl)
   );

   // Nothing may write while reset is held, even mid-instruction
   assign w_ctrl_out      = reset ? '0 : w_ctrl;

   assign bus.PCWrite     = w_ctrl_out.PCWrite;
   assign bus.PCWriteCond = w_ctrl_out.PCWriteCond;
   assign bus.IorD        = w_ctrl_out.IorD;
   assign bus.MemRead     = w_ctrl_out.MemRead;
   assign bus.MemWrite    = w_ctrl_out.MemWrite;
   assign bus.IRWrite     = w_ctrl_out.IRWrite;
   assign bus.MemtoReg    = w_ctrl_out.MemtoReg;
   assign bus.RegWrite    = w_ctrl_out.RegWrite;
   assign bus.RegDst      = w_ctrl_out.RegDst;
   assign bus.ALUSrcA     = w_ctrl_out.ALUSrcA;
   assign bus.ALUSrcB     = w_ctrl_out.ALUSrcB;
   assign bus.ALUOp       = w_ctrl_out.ALUOp;
   assign bus.PCSource    = w_ctrl_out.PCSource;
   assign bus.illegal_op  = w_ctrl_out.illegal_op;
   assign bus.state       = reset ? 4'd0 : 4'(r_state);
   assign bus.retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_control
// Purpose  : Self-checking bench for mips_multicycle_control. Two instances
//            (32-bit and 4-bit retire counters) see identical stimulus.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

   // Expected control word:
   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
   //  RegDst,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
   localparam logic [15:0] E_ZERO   = 16'h0000;
   localparam logic [15:0] E_FETCH  = {10'b1001010000, 2'b01, 2'b00, 2'b00};
   localparam logic [15:0] E_FWAIT  = {10'b0001000000, 2'b01, 2'b00, 2'b00};
   localparam logic [15:0] E_DECODE = {10'b0000000000, 2'b11, 2'b00, 2'b00};
   localparam logic [15:0] E_MADDR  = {10'b0000000001, 2'b10, 2'b00, 2'b00};
   localparam logic [15:0] E_MREAD  = {10'b0011000000, 2'b00, 2'b00, 2'b00};
   localparam logic [15:0] E_MWB    = {10'b0000001100, 2'b00, 2'b00, 2'b00};
   localparam logic [15:0] E_MWRITE = {10'b0010100000, 2'b00, 2'b00, 2'b00};
   localparam logic [15:0] E_EXEC   = {10'b0000000001, 2'b00, 2'b10, 2'b00};
   localparam logic [15:0] E_RWB    = {10'b0000000110, 2'b00, 2'b00, 2'b00};
   localparam logic [15:0] E_BRANCH = {10'b0100000001, 2'b00, 2'b01, 2'b01};
   localparam logic [15:0] E_JUMP   = {10'b1000000000, 2'b00, 2'b00, 2'b10};
   localparam logic [15:0] E_AWB    = {10'b0000000100, 2'b00, 2'b00, 2'b00};

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;
   localparam logic [5:0] XX = 6'b111111;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        zero;
      logic        mr;
      logic [3:0]  st;
      logic [15:0] ctl;
      logic        ill;
      int          ret;
   } vec_t;

   logic       clk = 1'b0;
   logic       t_rst;
   logic [5:0] t_op;
   logic       t_zero;
   logic       t_mr;
   int         checks = 0;
   int         errors = 0;
   int         vidx = 0;
   vec_t       vq[$];

   always #5 clk = ~clk;

   mips_multicycle_control_if #(.COUNT_W(32)) bus32 ();
   mips_multicycle_control_if #(.COUNT_W(4))  bus4 ();

   assign bus32.opCode = t_op;   assign bus4.opCode = t_op;
   assign bus32.zero = t_zero;   assign bus4.zero = t_zero;
   assign bus32.mem_ready = t_mr; assign bus4.mem_ready = t_mr;

   mips_multicycle_control #(.COUNT_W(32)) dut32 (.clk(clk), .reset(t_rst), .bus(bus32));
   mips_multicycle_control #(.COUNT_W(4))  dut4  (.clk(clk), .reset(t_rst), .bus(bus4));

   logic [15:0] act_ctl;
   assign act_ctl = {bus32.PCWrite, bus32.PCWriteCond, bus32.IorD, bus32.MemRead,
                     bus32.MemWrite, bus32.IRWrite, bus32.MemtoReg, bus32.RegWrite,
                     bus32.RegDst, bus32.ALUSrcA, bus32.ALUSrcB, bus32.ALUOp,
                     bus32.PCSource};

   task automatic chk(string tag, int idx, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", tag, idx, act, exp);
      end
   endtask

   task automatic add(logic rst, logic [5:0] op, logic zero, logic mr,
                      logic [3:0] st, logic [15:0] ctl, logic ill, int ret);
      vec_t v;
      v.rst = rst; v.op = op; v.zero = zero; v.mr = mr;
      v.st = st; v.ctl = ctl; v.ill = ill; v.ret = ret;
      vq.push_back(v);
   endtask

   // Drive one cycle's inputs after the falling edge, check before the rise
   task automatic run(vec_t v);
      @(negedge clk);
      t_rst = v.rst; t_op = v.op; t_zero = v.zero; t_mr = v.mr;
      #1;
      chk("state",   vidx, 32'(bus32.state),      32'(v.st));
      chk("ctrl",    vidx, 32'(act_ctl),          32'(v.ctl));
      chk("illegal", vidx, 32'(bus32.illegal_op), 32'(v.ill));
      chk("ret32",   vidx, bus32.retired,         32'(v.ret));
      chk("ret4",    vidx, 32'(bus4.retired),     32'(v.ret % 16));
      vidx++;
   endtask

   task automatic run1(logic rst, logic [5:0] op, logic zero, logic mr,
                       logic [3:0] st, logic [15:0] ctl, logic ill, int ret);
      vec_t v;
      v.rst = rst; v.op = op; v.zero = zero; v.mr = mr;
      v.st = st; v.ctl = ctl; v.ill = ill; v.ret = ret;
      run(v);
   endtask

   initial begin
      t_rst = 1'b1; t_op = RT; t_zero = 1'b0; t_mr = 1'b1;

      //   rst op  z  mr  st  ctl       ill ret
      add(1, RT, 0, 1, 0,  E_ZERO,   0, 0);   // reset held
      add(1, RT, 0, 1, 0,  E_ZERO,   0, 0);
      // R-type; opCode junk outside DECODE must be ignored
      add(0, RT, 0, 1, 0,  E_FETCH,  0, 0);
      add(0, RT, 0, 1, 1,  E_DECODE, 0, 0);
      add(0, XX, 0, 1, 6,  E_EXEC,   0, 0);
      add(0, XX, 0, 1, 7,  E_RWB,    0, 0);
      // lw with two wait cycles in MEM_READ
      add(0, LW, 0, 1, 0,  E_FETCH,  0, 1);
      add(0, LW, 0, 1, 1,  E_DECODE, 0, 1);
      add(0, LW, 0, 1, 2,  E_MADDR,  0, 1);
      add(0, LW, 0, 0, 3,  E_MREAD,  0, 1);
      add(0, LW, 0, 0, 3,  E_MREAD,  0, 1);
      add(0, LW, 0, 1, 3,  E_MREAD,  0, 1);
      add(0, LW, 0, 1, 4,  E_MWB,    0, 1);
      // sw, then beq with zero=1
      add(0, SW, 0, 1, 0,  E_FETCH,  0, 2);
      add(0, SW, 0, 1, 1,  E_DECODE, 0, 2);
      add(0, SW, 0, 1, 2,  E_MADDR,  0, 2);
      add(0, SW, 0, 1, 5,  E_MWRITE, 0, 2);
      add(0, BQ, 1, 1, 0,  E_FETCH,  0, 3);
      add(0, BQ, 1, 1, 1,  E_DECODE, 0, 3);
      add(0, BQ, 1, 1, 8,  E_BRANCH, 0, 3);
      // FETCH stalled 3 cycles, then addi
      add(0, AI, 0, 0, 0,  E_FWAIT,  0, 4);
      add(0, AI, 0, 0, 0,  E_FWAIT,  0, 4);
      add(0, AI, 0, 0, 0,  E_FWAIT,  0, 4);
      add(0, AI, 0, 1, 0,  E_FETCH,  0, 4);
      add(0, AI, 0, 1, 1,  E_DECODE, 0, 4);
      add(0, AI, 0, 1, 10, E_MADDR,  0, 4);
      add(0, AI, 0, 1, 11, E_AWB,    0, 4);
      // j
      add(0, JJ, 0, 1, 0,  E_FETCH,  0, 5);
      add(0, JJ, 0, 1, 1,  E_DECODE, 0, 5);
      add(0, JJ, 0, 1, 9,  E_JUMP,   0, 5);
      // sw stalled one cycle in MEM_WRITE: retires only on completion
      add(0, SW, 0, 1, 0,  E_FETCH,  0, 6);
      add(0, SW, 0, 1, 1,  E_DECODE, 0, 6);
      add(0, SW, 0, 1, 2,  E_MADDR,  0, 6);
      add(0, SW, 0, 0, 5,  E_MWRITE, 0, 6);
      add(0, SW, 0, 1, 5,  E_MWRITE, 0, 6);
      // illegal opcode
      add(0, XX, 0, 1, 0,  E_FETCH,  0, 7);
      add(0, XX, 0, 1, 1,  E_DECODE, 0, 7);

      for (int i = 0; i < vq.size(); i++) run(vq[i]);

      // TRAP is absorbing regardless of opCode / mem_ready
      for (int i = 0; i < 20; i++)
         run1(0, (i % 2 == 0) ? RT : JJ, 1'(i % 3 == 0), 1'(i % 2), 15, E_ZERO, 1, 7);
      // Reset leaves TRAP
      run1(1, RT, 0, 1, 0, E_ZERO, 0, 7);
      run1(0, JJ, 0, 1, 0, E_FETCH, 0, 0);

      // 16 back-to-back jumps: the 4-bit counter wraps to 0
      for (int k = 0; k < 16; k++) begin
         if (k != 0) run1(0, JJ, 0, 1, 0, E_FETCH, 0, k);
         run1(0, JJ, 0, 1, 1, E_DECODE, 0, k);
         run1(0, JJ, 0, 1, 9, E_JUMP,   0, k);
      end
      run1(0, RT, 0, 1, 0, E_FETCH, 0, 16);
      chk("wrap4", vidx, 32'(bus4.retired), 32'd0);

      // Reset during EXECUTE: no RegWrite, restart at FETCH
      run1(0, RT, 0, 1, 1, E_DECODE, 0, 16);
      run1(1, RT, 0, 1, 0, E_ZERO,   0, 16);
      run1(0, RT, 0, 1, 0, E_FETCH,  0, 0);
      run1(0, RT, 0, 1, 1, E_DECODE, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
